// File: rtl/centroid_pkg.sv
// Shared types and default widths for the mask centroid reducer.
package centroid_pkg;

  localparam int unsigned X_W   = 11;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned CNT_W = 20;
  localparam int unsigned SUM_W = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDivide = 2'd1,
    StDone   = 2'd2
  } state_e;

endpackage

// File: rtl/mask_centroid_if.sv
// Pixel-mask input stream and per-frame centroid/bbox result bundle.
interface mask_centroid_if #(
  parameter int unsigned X_W = centroid_pkg::X_W,
  parameter int unsigned Y_W = centroid_pkg::Y_W
);

  logic [X_W-1:0] x_in;
  logic [Y_W-1:0] y_in;
  logic           valid_in;
  logic           mask_in;
  logic           frame_done_in;

  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic           valid_out;
  logic           busy_out;
  logic [X_W-1:0] bbox_min_x_out;
  logic [X_W-1:0] bbox_max_x_out;
  logic [Y_W-1:0] bbox_min_y_out;
  logic [Y_W-1:0] bbox_max_y_out;

  modport master (
    output x_in, y_in, valid_in, mask_in, frame_done_in,
    input  x_out, y_out, valid_out, busy_out,
    input  bbox_min_x_out, bbox_max_x_out, bbox_min_y_out, bbox_max_y_out
  );

  modport slave (
    input  x_in, y_in, valid_in, mask_in, frame_done_in,
    output x_out, y_out, valid_out, busy_out,
    output bbox_min_x_out, bbox_max_x_out, bbox_min_y_out, bbox_max_y_out
  );

endinterface

// File: rtl/centroid_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle. The first
// step runs on the start edge, so done pulses DVD_W cycles after start.
module centroid_divider #(
  parameter int unsigned DVD_W = 32,
  parameter int unsigned DVS_W = 20,
  parameter int unsigned QUO_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic [QUO_W-1:0] quotient_o,
  output logic             done_o
);

  localparam int unsigned CntW = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] rem_q, rem_d, dvs_q, dvs_d, src_rem, src_dvs, step_rem;
  logic [DVD_W-1:0] dvd_q, dvd_d, src_dvd, step_dvd;
  logic [DVS_W:0]   trial, diff;
  logic             qbit;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             run_q, run_d, done_q, done_d;

  // One restoring step; quotient bits shift into the vacated dividend LSBs.
  always_comb begin
    src_rem  = start_i ? '0 : rem_q;
    src_dvd  = start_i ? dividend_i : dvd_q;
    src_dvs  = start_i ? divisor_i : dvs_q;
    trial    = {src_rem, src_dvd[DVD_W-1]};
    diff     = trial - {1'b0, src_dvs};
    qbit     = (trial >= {1'b0, src_dvs});
    step_rem = qbit ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
    step_dvd = {src_dvd[DVD_W-2:0], qbit};
  end

  always_comb begin
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start_i) begin
      rem_d  = step_rem;
      dvd_d  = step_dvd;
      dvs_d  = divisor_i;
      cnt_d  = CntW'(DVD_W - 1);
      run_d  = (DVD_W > 1);
      done_d = (DVD_W == 1);
    end else if (run_q) begin
      rem_d = step_rem;
      dvd_d = step_dvd;
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient_o = dvd_q[QUO_W-1:0];
  assign done_o     = done_q;

endmodule

// File: rtl/mask_centroid.sv
// Reduces each frame's masked pixels to a centroid (and, with
// MASK_CENTROID_BBOX_EN defined, a bounding box); divides while the next frame accumulates.
module mask_centroid #(
  parameter int unsigned X_W   = centroid_pkg::X_W,
  parameter int unsigned Y_W   = centroid_pkg::Y_W,
  parameter int unsigned CNT_W = centroid_pkg::CNT_W,
  parameter int unsigned SUM_W = centroid_pkg::SUM_W
) (
  input  logic          clk_in,
  input  logic          rst_in,
  mask_centroid_if.slave bus
);

  import centroid_pkg::*;

  logic             pix;
  logic [SUM_W-1:0] sum_x_q, sum_x_d, sum_x_acc;
  logic [SUM_W-1:0] sum_y_q, sum_y_d, sum_y_acc;
  logic [SUM_W:0]   sum_x_wide, sum_y_wide;
  logic [CNT_W-1:0] count_q, count_d, count_acc;
  logic             start, publish, x_done, y_done;
  logic [X_W-1:0]   x_quo, x_out_q;
  logic [Y_W-1:0]   y_quo, y_out_q;
  state_e           state_q, state_d;

  assign pix = bus.valid_in & bus.mask_in;

  // Accumulated values include the current pixel, so a pixel coincident
  // with frame_done_in lands in the closing frame's totals.
  always_comb begin
    sum_x_wide = {1'b0, sum_x_q} + {{(SUM_W + 1 - X_W){1'b0}}, bus.x_in};
    sum_y_wide = {1'b0, sum_y_q} + {{(SUM_W + 1 - Y_W){1'b0}}, bus.y_in};
    sum_x_acc  = sum_x_q;
    sum_y_acc  = sum_y_q;
    count_acc  = count_q;
    if (pix) begin
      sum_x_acc = sum_x_wide[SUM_W] ? '1 : sum_x_wide[SUM_W-1:0];
      sum_y_acc = sum_y_wide[SUM_W] ? '1 : sum_y_wide[SUM_W-1:0];
      if (count_q != {CNT_W{1'b1}}) count_acc = count_q + CNT_W'(1);
    end
    sum_x_d = bus.frame_done_in ? '0 : sum_x_acc;
    sum_y_d = bus.frame_done_in ? '0 : sum_y_acc;
    count_d = bus.frame_done_in ? '0 : count_acc;
  end

  assign start   = bus.frame_done_in && (state_q == StIdle) && (count_acc != '0);
  assign publish = (state_q == StDivide) && x_done && y_done;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StDivide;
      StDivide: if (publish) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      sum_x_q <= '0;
      sum_y_q <= '0;
      count_q <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
    end else begin
      state_q <= state_d;
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
      count_q <= count_d;
      if (publish) begin
        x_out_q <= x_quo;
        y_out_q <= y_quo;
      end
    end
  end

  centroid_divider #(
    .DVD_W(SUM_W),
    .DVS_W(CNT_W),
    .QUO_W(X_W)
  ) u_div_x (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .start_i   (start),
    .dividend_i(sum_x_acc),
    .divisor_i (count_acc),
    .quotient_o(x_quo),
    .done_o    (x_done)
  );

  centroid_divider #(
    .DVD_W(SUM_W),
    .DVS_W(CNT_W),
    .QUO_W(Y_W)
  ) u_div_y (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .start_i   (start),
    .dividend_i(sum_y_acc),
    .divisor_i (count_acc),
    .quotient_o(y_quo),
    .done_o    (y_done)
  );

  assign bus.x_out     = x_out_q;
  assign bus.y_out     = y_out_q;
  assign bus.valid_out = (state_q == StDone);
  assign bus.busy_out  = (state_q != StIdle);

`ifdef MASK_CENTROID_BBOX_EN
  logic [X_W-1:0] min_x_q, min_x_d, min_x_acc, max_x_q, max_x_d, max_x_acc;
  logic [Y_W-1:0] min_y_q, min_y_d, min_y_acc, max_y_q, max_y_d, max_y_acc;
  logic [X_W-1:0] snap_min_x_q, snap_max_x_q, pub_min_x_q, pub_max_x_q;
  logic [Y_W-1:0] snap_min_y_q, snap_max_y_q, pub_min_y_q, pub_max_y_q;

  always_comb begin
    min_x_acc = (pix && (bus.x_in < min_x_q)) ? bus.x_in : min_x_q;
    max_x_acc = (pix && (bus.x_in > max_x_q)) ? bus.x_in : max_x_q;
    min_y_acc = (pix && (bus.y_in < min_y_q)) ? bus.y_in : min_y_q;
    max_y_acc = (pix && (bus.y_in > max_y_q)) ? bus.y_in : max_y_q;
    min_x_d   = bus.frame_done_in ? '1 : min_x_acc;
    max_x_d   = bus.frame_done_in ? '0 : max_x_acc;
    min_y_d   = bus.frame_done_in ? '1 : min_y_acc;
    max_y_d   = bus.frame_done_in ? '0 : max_y_acc;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      min_x_q      <= '1;
      max_x_q      <= '0;
      min_y_q      <= '1;
      max_y_q      <= '0;
      snap_min_x_q <= '1;
      snap_max_x_q <= '0;
      snap_min_y_q <= '1;
      snap_max_y_q <= '0;
      pub_min_x_q  <= '1;
      pub_max_x_q  <= '0;
      pub_min_y_q  <= '1;
      pub_max_y_q  <= '0;
    end else begin
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      // Only a frame that actually enters the divider is snapshotted.
      if (start) begin
        snap_min_x_q <= min_x_acc;
        snap_max_x_q <= max_x_acc;
        snap_min_y_q <= min_y_acc;
        snap_max_y_q <= max_y_acc;
      end
      if (publish) begin
        pub_min_x_q <= snap_min_x_q;
        pub_max_x_q <= snap_max_x_q;
        pub_min_y_q <= snap_min_y_q;
        pub_max_y_q <= snap_max_y_q;
      end
    end
  end

  assign bus.bbox_min_x_out = pub_min_x_q;
  assign bus.bbox_max_x_out = pub_max_x_q;
  assign bus.bbox_min_y_out = pub_min_y_q;
  assign bus.bbox_max_y_out = pub_max_y_q;
`else
  assign bus.bbox_min_x_out = '0;
  assign bus.bbox_max_x_out = '0;
  assign bus.bbox_min_y_out = '0;
  assign bus.bbox_max_y_out = '0;
`endif

endmodule

// File: tb/tb_mask_centroid.sv
// Scoreboard bench for mask_centroid: directed frames push expected results,
// a negedge monitor pops and compares on each valid_out.
module tb_mask_centroid;
  import centroid_pkg::*;

  typedef struct {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] min_x;
    logic [X_W-1:0] max_x;
    logic [Y_W-1:0] min_y;
    logic [Y_W-1:0] max_y;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mask_centroid_if bus ();

  mask_centroid dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  int   checks    = 0;
  int   errors    = 0;
  int   valid_cnt = 0;
  bit   rst_seen  = 1'b1;
  exp_t sb[$];
  logic [X_W-1:0] prev_x;
  logic [Y_W-1:0] prev_y;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input int x, input int y, input int mnx, input int mxx,
                              input int mny, input int mxy);
    exp_t e;
    e.x     = X_W'(x);
    e.y     = Y_W'(y);
    e.min_x = X_W'(mnx);
    e.max_x = X_W'(mxx);
    e.min_y = Y_W'(mny);
    e.max_y = Y_W'(mxy);
    return e;
  endfunction

  // Monitor: compares every published result and checks outputs hold otherwise.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (bus.valid_out) begin
        valid_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual 1 required 0 at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("x_out", int'(bus.x_out), int'(e.x));
          check("y_out", int'(bus.y_out), int'(e.y));
`ifdef MASK_CENTROID_BBOX_EN
          check("bbox_min_x", int'(bus.bbox_min_x_out), int'(e.min_x));
          check("bbox_max_x", int'(bus.bbox_max_x_out), int'(e.max_x));
          check("bbox_min_y", int'(bus.bbox_min_y_out), int'(e.min_y));
          check("bbox_max_y", int'(bus.bbox_max_y_out), int'(e.max_y));
`else
          check("bbox_min_x", int'(bus.bbox_min_x_out), 0);
          check("bbox_max_y", int'(bus.bbox_max_y_out), 0);
`endif
        end
      end else if (!rst_seen) begin
        check("x_hold", int'(bus.x_out), int'(prev_x));
        check("y_hold", int'(bus.y_out), int'(prev_y));
      end
      prev_x   = bus.x_out;
      prev_y   = bus.y_out;
      rst_seen = 1'b0;
    end
  end

  task automatic drive(input int x, input int y, input bit v, input bit m, input bit fd);
    bus.x_in          = X_W'(x);
    bus.y_in          = Y_W'(y);
    bus.valid_in      = v;
    bus.mask_in       = m;
    bus.frame_done_in = fd;
    @(posedge clk);
    #1;
    bus.valid_in      = 1'b0;
    bus.mask_in       = 1'b0;
    bus.frame_done_in = 1'b0;
  endtask

  task automatic pixel(input int x, input int y);
    drive(x, y, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called at cycle 1 after frame_done_in; bounded wait for valid_out.
  task automatic wait_valid(input string name);
    int n;
    n = 1;
    check({name, "_busy_c1"}, int'(bus.busy_out), 1);
    while (!bus.valid_out && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, n, 33);
    @(posedge clk);
    #1;
    check({name, "_busy_after"}, int'(bus.busy_out), 0);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_x"}, int'(bus.x_out), 0);
    check({name, "_y"}, int'(bus.y_out), 0);
    check({name, "_valid"}, int'(bus.valid_out), 0);
    check({name, "_busy"}, int'(bus.busy_out), 0);
`ifdef MASK_CENTROID_BBOX_EN
    check({name, "_min_x"}, int'(bus.bbox_min_x_out), 2047);
    check({name, "_max_x"}, int'(bus.bbox_max_x_out), 0);
    check({name, "_min_y"}, int'(bus.bbox_min_y_out), 1023);
    check({name, "_max_y"}, int'(bus.bbox_max_y_out), 0);
`else
    check({name, "_min_x"}, int'(bus.bbox_min_x_out), 0);
    check({name, "_min_y"}, int'(bus.bbox_min_y_out), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    bus.x_in          = '0;
    bus.y_in          = '0;
    bus.valid_in      = 1'b0;
    bus.mask_in       = 1'b0;
    bus.frame_done_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    idle(2);

    // 10x10 square with non-qualified and unmasked pixels interleaved.
    for (int y = 50; y < 60; y++) begin
      for (int x = 100; x < 110; x++) pixel(x, y);
      drive(5, 5, 1'b1, 1'b0, 1'b0);
      drive(0, 0, 1'b0, 1'b1, 1'b0);
    end
    sb.push_back(mk(104, 54, 100, 109, 50, 59));
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    wait_valid("square");

    // Single pixel at the far corner.
    pixel(1023, 767);
    sb.push_back(mk(1023, 767, 1023, 1023, 767, 767));
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    wait_valid("corner");

    // Empty frame: no result, previous outputs held.
    idle(3);
    v0 = valid_cnt;
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    check("empty_busy", int'(bus.busy_out), 0);
    idle(40);
    check("empty_no_valid", valid_cnt - v0, 0);
    check("empty_hold_x", int'(bus.x_out), 1023);
    check("empty_hold_y", int'(bus.y_out), 767);

    // Pixel coincident with frame_done belongs to the closing frame.
    sb.push_back(mk(20, 30, 20, 20, 30, 30));
    drive(20, 30, 1'b1, 1'b1, 1'b1);
    wait_valid("coincident");
    pixel(5, 7);
    sb.push_back(mk(5, 7, 5, 5, 7, 7));
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    wait_valid("after_coincident");

    // Second frame_done five cycles into DIVIDE is discarded.
    pixel(200, 100);
    sb.push_back(mk(200, 100, 200, 200, 100, 100));
    v0 = valid_cnt;
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    pixel(300, 300);
    pixel(301, 300);
    pixel(302, 301);
    idle(1);
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    pixel(40, 60);
    idle(40);
    check("discard_one_valid", valid_cnt - v0, 1);
    check("discard_idle", int'(bus.busy_out), 0);
    sb.push_back(mk(40, 60, 40, 40, 60, 60));
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    wait_valid("after_discard");

    // Reset mid-DIVIDE aborts the division.
    pixel(500, 400);
    sb.push_back(mk(500, 400, 500, 500, 400, 400));
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    idle(10);
    #1;
    rst = 1'b1;
    rst_seen = 1'b1;
    #1;
    check_reset_state("midreset");
    sb.delete();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    v0 = valid_cnt;
    idle(45);
    check("midreset_no_valid", valid_cnt - v0, 0);
    pixel(60, 70);
    sb.push_back(mk(60, 70, 60, 60, 70, 70));
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    wait_valid("after_reset");

    idle(3);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mask_centroid.md
# mask_centroid

Consumes the per-pixel mask stream produced by the threshold stage and reduces each frame to one centroid (mean x, mean y of all masked pixels). It sits after the threshold stage and feeds tracker/overlay logic with one result per frame. Accumulation runs at pixel rate. The per-frame division runs in a multi-cycle sequential divider, and accumulation of the next frame continues during it.

## Interface
- `X_W`, 11: pixel x-coordinate width (hcount).
- `Y_W`, 10: pixel y-coordinate width (vcount).
- `CNT_W`, 20: masked-pixel counter width; covers at least 1024×768.
- `SUM_W`, 32: coordinate sum width; also the divider iteration count.

Ports:
- `clk_in` input 1: pixel clock; single clock domain.
- `rst_in` input 1: asynchronous, active-high reset.
- `x_in` input X_W: current pixel column.
- `y_in` input Y_W: current pixel row.
- `valid_in` input 1: pixel qualifier; `x_in`/`y_in`/`mask_in` are meaningful only when high.
- `mask_in` input 1: threshold result for this pixel.
- `frame_done_in` input 1: one-cycle pulse closing the current frame.
- `x_out` output X_W: floor(sum_x / count) of the last reported frame.
- `y_out` output Y_W: floor(sum_y / count) of the last reported frame.
- `valid_out` output 1: one-cycle pulse when `x_out`/`y_out` update.
- `busy_out` output 1: high while the divider is working.
- `bbox_min_x_out`, `bbox_max_x_out` output X_W: bounding box x limits (see Configuration).
- `bbox_min_y_out`, `bbox_max_y_out` output Y_W: bounding box y limits (see Configuration).

## Operation
- **Accumulators** `sum_x` (SUM_W), `sum_y` (SUM_W) and `count` (CNT_W):
  - On `valid_in && mask_in`: add `x_in`, add `y_in`, increment `count`.
  - Zero-extended unsigned arithmetic.
  - Saturate at all-ones instead of wrapping.
- **`frame_done_in` cycle:**
  - If that same cycle carries a masked pixel, the pixel belongs to the closing frame.
  - The closing totals are snapshotted and all accumulators clear at the same clock edge.
  - The next frame's accumulation starts on the following cycle.
- **FSM states**, reset state IDLE:
  - IDLE:
    - `frame_done_in` with `count` (including the coincident pixel) > 0 → DIVIDE.
    - `frame_done_in` with `count` == 0 → stay in IDLE. Outputs hold and `valid_out` stays low.
  - DIVIDE: runs two identical restoring dividers in parallel, one quotient bit per cycle, SUM_W cycles. → DONE.
  - DONE: registers the quotient low bits into `x_out`/`y_out` and asserts `valid_out` for one cycle. → IDLE.
- **`frame_done_in` while in DIVIDE or DONE:**
  - The in-progress result is unaffected.
  - The newly closed frame is discarded: its accumulators clear and no second result is produced.
- Quotients are at most the maximum coordinate, so truncation to X_W/Y_W is lossless.
- `busy_out` = (state != IDLE).

## Timing
- Reset values:
  - State IDLE.
  - All accumulators 0.
  - `x_out`, `y_out`, `valid_out`, `busy_out` all 0.
  - bbox mins all-ones; bbox maxes 0.
- Latency: `frame_done_in` sampled in cycle 0 → `busy_out` high from cycle 1 → `valid_out` high in cycle SUM_W+1 only (33 at default). IDLE again at cycle SUM_W+2.
- Reset asserted mid-DIVIDE aborts the division immediately. No `valid_out` follows.
- `x_out`/`y_out` change only in the `valid_out` cycle and are stable otherwise.
- Pixels at full rate, one per clock, are accepted in every state with no backpressure.

## Configuration
- `MASK_CENTROID_BBOX_EN` defined:
  - Per-frame min/max x and y of masked pixels are tracked.
  - They are snapshotted at `frame_done_in` and published on the bbox ports in the `valid_out` cycle.
  - Running trackers reset to min all-ones / max 0 at each frame close.
- Not defined:
  - No tracking logic is built.
  - The bbox ports remain and are driven constant 0.

## Structure
- Shared package `centroid_pkg` holds:
  - The FSM state enum (IDLE, DIVIDE, DONE).
  - Default width constants `X_W`, `Y_W`, `CNT_W`, `SUM_W`.
- One sub-module, `centroid_divider`:
  - Sequential unsigned restoring divider, parameterized dividend/divisor widths.
  - Start pulse in, quotient and done pulse out.
  - Instantiated twice, for x and y.

## Test plan
- 10×10 masked square, x 100..109, y 50..59, then `frame_done_in` → `valid_out` after 33 cycles; `x_out`=104, `y_out`=54; with the macro, bbox = 100/109, 50/59.
- Single masked pixel (1023, 767) → `x_out`=1023, `y_out`=767.
- Frame with no masked pixels, then `frame_done_in` → `valid_out` never asserts; previous outputs held.
- Masked pixel (20, 30) in the same cycle as `frame_done_in` on an otherwise empty frame → result 20/30. The next frame starts with `count`=0.
- Second `frame_done_in` 5 cycles into DIVIDE → first result correct; exactly one `valid_out`; the second frame is discarded.
- `rst_in` pulsed mid-DIVIDE → all outputs 0 immediately, no `valid_out`; the next frame produces a correct result.
